sr_rw_ctrl: RTL and testbench

// - Sequences one full write/readback transaction on the TMIIa configuration shift register.
// - Serialises a DATA_WIDTH-bit config word onto din_sr, then pulses load_sr.
// - Clocks the register contents back via dout_sr and presents the captured word plus a compare flag.
// - Sits between the host register bank (start/din/dout) and the chip SR pins (clk_sr/din_sr/load_sr/dout_sr).

---
 rtl/sr_rw_ctrl_if.sv | 26 ++
 rtl/sr_rw_ctrl.sv | 141 ++++++++++++++
 tb/tb_sr_rw_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sr_rw_ctrl_if.sv
// Host/chip-side signal bundle for the configuration shift-register write/readback controller.
// The master side is the host register bank plus the chip's readback pin; the slave side is the controller.
interface sr_rw_ctrl_if #(
   parameter int DATA_WIDTH = 170
);
   logic                  start;
   logic [DATA_WIDTH-1:0] din;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] dout;
   logic                  match;
   logic                  clk_sr;
   logic                  din_sr;
   logic                  load_sr;
   logic                  dout_sr;

   modport master (
      output start, din, dout_sr,
      input  busy, done, dout, match, clk_sr, din_sr, load_sr
   );

   modport slave (
      input  start, din, dout_sr,
      output busy, done, dout, match, clk_sr, din_sr, load_sr
   );
endinterface

// File: rtl/sr_rw_ctrl.sv
// Writes one config word serially into the chip shift register, strobes load, then reads it back.
// Build option SR_RW_CMP_EN adds the readback == written comparator driving match.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | serialising wr_q onto din_sr, LSB first
// LOAD  | one bit period with load_sr high
// READ  | clocking readback bits from dout_sr into rd_q
// DONE  | one-cycle completion pulse
module sr_rw_ctrl #(
   parameter int DATA_WIDTH = 170,
   parameter int CNT_WIDTH  = 8,
   parameter int DIV_HALF   = 2
) (
   input logic         clk,
   input logic         rst,
   sr_rw_ctrl_if.slave bus
);
   localparam int P     = 2 * DIV_HALF;
   localparam int DIV_W = (P > 2) ? $clog2(P) : 1;

   typedef enum logic [2:0] {IDLE, SHIFT, LOAD, READ, DONE} state_t;

   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [DATA_WIDTH-1:0] wr_q, wr_d;
   logic [DATA_WIDTH-1:0] rd_q, rd_d;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  clk_sr_q, clk_sr_d;
   logic                  din_sr_q, din_sr_d;
   logic                  load_sr_q, load_sr_d;
   logic                  period_end, last_bit, enter_done;

   assign period_end = (div_q == DIV_W'(P - 1));
   assign last_bit   = (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      enter_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               wr_d    = bus.din;
               cnt_d   = '0;
               div_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            div_d = period_end ? '0 : div_q + DIV_W'(1);
            if (period_end) begin
               if (last_bit) begin
                  cnt_d   = '0;
                  state_d = LOAD;
               end else begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
            end
         end
         LOAD: begin
            div_d = period_end ? '0 : div_q + DIV_W'(1);
            if (period_end) state_d = READ;
         end
         READ: begin
            div_d = period_end ? '0 : div_q + DIV_W'(1);
            if (period_end) begin
               // Shifting in from the top lands the first-read bit at index 0 after DATA_WIDTH bits.
               rd_d = {bus.dout_sr, rd_q[DATA_WIDTH-1:1]};
               if (last_bit) begin
                  cnt_d      = '0;
                  state_d    = DONE;
                  enter_done = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Pin values are computed from next state so the registered pins line up with the state.
      clk_sr_d  = ((state_d == SHIFT) || (state_d == READ)) && (div_d >= DIV_W'(DIV_HALF));
      load_sr_d = (state_d == LOAD);
      din_sr_d  = 1'b0;
      if (state_d == SHIFT) begin
         for (int i = 0; i < DATA_WIDTH; i++) begin
            if (cnt_d == CNT_WIDTH'(i)) din_sr_d = wr_d[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         div_q     <= '0;
         wr_q      <= '0;
         rd_q      <= '0;
         dout_q    <= '0;
         clk_sr_q  <= 1'b0;
         din_sr_q  <= 1'b0;
         load_sr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         clk_sr_q  <= clk_sr_d;
         din_sr_q  <= din_sr_d;
         load_sr_q <= load_sr_d;
         if (enter_done) dout_q <= rd_d;
      end
   end

`ifdef SR_RW_CMP_EN
   logic match_q;

   always_ff @(posedge clk) begin
      if (rst)             match_q <= 1'b0;
      else if (enter_done) match_q <= (rd_d == wr_q);
   end

   assign bus.match = match_q;
`else
   assign bus.match = 1'b0;
`endif

   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = (state_q == DONE);
   assign bus.dout    = dout_q;
   assign bus.clk_sr  = clk_sr_q;
   assign bus.din_sr  = din_sr_q;
   assign bus.load_sr = load_sr_q;
endmodule

// File: tb/tb_sr_rw_ctrl.sv
// Bench for sr_rw_ctrl: 8-bit instance against a chip shift-register model, plus a 170-bit default instance.
module tb_sr_rw_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

`ifdef SR_RW_CMP_EN
   localparam bit CMP_EN = 1'b1;
`else
   localparam bit CMP_EN = 1'b0;
`endif

   sr_rw_ctrl_if #(.DATA_WIDTH(8))   if_a ();
   sr_rw_ctrl_if #(.DATA_WIDTH(170)) if_b ();

   sr_rw_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(8), .DIV_HALF(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a.slave)
   );

   sr_rw_ctrl dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b.slave)
   );

   assign if_b.dout_sr = 1'b1;

   // Chip model: 8-bit SR shifting din_sr in on clk_sr rise, readback copy taken on load_sr.
   logic [7:0] chip_sr     = '0;
   logic [7:0] chip_rb     = '0;
   logic [7:0] flip_mask   = '0;
   logic       chip_out    = 1'b0;
   logic       clk_sr_prev = 1'b0;
   bit         din_log[$];

   always @(posedge clk) begin
      if (if_a.clk_sr && !clk_sr_prev) begin
         chip_sr  <= {if_a.din_sr, chip_sr[7:1]};
         chip_out <= chip_rb[0];
         chip_rb  <= {1'b0, chip_rb[7:1]};
         din_log.push_back(if_a.din_sr);
      end else if (if_a.load_sr) begin
         chip_rb <= chip_sr ^ flip_mask;
      end
      clk_sr_prev <= if_a.clk_sr;
   end

   assign if_a.dout_sr = chip_out;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0] w;
      logic [7:0] flip;
      int         second_k;
      logic [7:0] exp_dout;
      logic       exp_m_cmp;
   } vec_t;

   vec_t vecs[6];

   // One transaction on the 8-bit instance; start is sampled at the posedge after the first negedge.
   task automatic run_check(input string tag, input logic [7:0] w, input logic [7:0] flip,
                            input int second_k, input logic [7:0] exp_dout, input logic exp_m);
      int         k, lat, ld, dones, logsz;
      logic       busy1, busy_after, dout_moved;
      logic [7:0] dq, d_prev, wr_bits;
      logic       mq;
      @(negedge clk);
      flip_mask = flip;
      din_log.delete();
      if_a.din   = w;
      if_a.start = 1'b1;
      d_prev     = if_a.dout;
      @(posedge clk);
      lat = -1; ld = 0; dones = 0; k = 0;
      busy1 = 1'b0; busy_after = 1'b1; dout_moved = 1'b0; dq = 'x; mq = 1'bx;
      while (k < 200) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            if_a.start = 1'b0;
            if_a.din   = ~w;
            busy1      = if_a.busy;
         end
         if (second_k != 0 && k == second_k) begin
            if_a.start = 1'b1;
            if_a.din   = 8'h00;
         end
         if (second_k != 0 && k == second_k + 1) if_a.start = 1'b0;
         if (if_a.load_sr) ld++;
         if (lat < 0 && !if_a.done && if_a.dout !== d_prev) dout_moved = 1'b1;
         if (if_a.done) begin
            dones++;
            if (lat < 0) begin
               lat = k;
               dq  = if_a.dout;
               mq  = if_a.match;
            end
         end
         if (lat > 0 && k == lat + 1) busy_after = if_a.busy;
         if (lat > 0 && k >= lat + 10) break;
      end
      logsz = din_log.size();
      for (int i = 0; i < 8; i++) wr_bits[i] = (i < logsz) ? din_log[i] : 1'bx;
      chk({tag, " busy_next"}, 32'(busy1), 32'd1);
      chk({tag, " latency"}, 32'(lat), 32'd69);
      chk({tag, " done_pulses"}, 32'(dones), 32'd1);
      chk({tag, " load_cycles"}, 32'(ld), 32'd4);
      chk({tag, " clk_sr_rises"}, 32'(logsz), 32'd16);
      chk({tag, " din_sr_bits"}, 32'(wr_bits), 32'(w));
      chk({tag, " dout"}, 32'(dq), 32'(exp_dout));
      chk({tag, " match"}, 32'(mq), 32'(exp_m));
      chk({tag, " busy_after_done"}, 32'(busy_after), 32'd0);
      chk({tag, " dout_early_change"}, 32'(dout_moved), 32'd0);
   endtask

   initial begin
      logic [7:0] w, flip;
      int         k, lat;
      rst        = 1'b1;
      if_a.start = 1'b0;
      if_a.din   = '0;
      if_b.start = 1'b0;
      if_b.din   = '0;

      vecs[0] = '{w: 8'hA5, flip: 8'h00, second_k: 0,  exp_dout: 8'hA5, exp_m_cmp: 1'b1};
      vecs[1] = '{w: 8'hA5, flip: 8'h08, second_k: 0,  exp_dout: 8'hAD, exp_m_cmp: 1'b0};
      vecs[2] = '{w: 8'hA5, flip: 8'h00, second_k: 20, exp_dout: 8'hA5, exp_m_cmp: 1'b1};
      vecs[3] = '{w: 8'h00, flip: 8'h00, second_k: 0,  exp_dout: 8'h00, exp_m_cmp: 1'b1};
      vecs[4] = '{w: 8'hFF, flip: 8'h01, second_k: 0,  exp_dout: 8'hFE, exp_m_cmp: 1'b0};
      vecs[5] = '{w: 8'h81, flip: 8'h80, second_k: 0,  exp_dout: 8'h01, exp_m_cmp: 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst busy", 32'(if_a.busy), 32'd0);
      chk("rst done", 32'(if_a.done), 32'd0);
      chk("rst clk_sr", 32'(if_a.clk_sr), 32'd0);
      chk("rst din_sr", 32'(if_a.din_sr), 32'd0);
      chk("rst load_sr", 32'(if_a.load_sr), 32'd0);
      chk("rst match", 32'(if_a.match), 32'd0);
      chk("rst dout", 32'(if_a.dout), 32'd0);
      chk("rst busy_b", 32'(if_b.busy), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle busy", 32'(if_a.busy), 32'd0);

      foreach (vecs[i])
         run_check($sformatf("vec%0d", i), vecs[i].w, vecs[i].flip, vecs[i].second_k,
                   vecs[i].exp_dout, CMP_EN && vecs[i].exp_m_cmp);

      // rst and start together: start must be dropped
      @(negedge clk);
      rst = 1'b1; if_a.start = 1'b1; if_a.din = 8'h5A;
      @(negedge clk);
      rst = 1'b0; if_a.start = 1'b0;
      chk("rst_start busy", 32'(if_a.busy), 32'd0);
      chk("rst_start dout", 32'(if_a.dout), 32'd0);
      repeat (3) @(negedge clk);
      chk("rst_start busy_later", 32'(if_a.busy), 32'd0);

      // Prime dout non-zero, then reset in the middle of SHIFT
      run_check("prime", 8'hC3, 8'h00, 0, 8'hC3, CMP_EN);
      @(negedge clk);
      if_a.din = 8'h3C; if_a.start = 1'b1;
      @(posedge clk);
      k = 0;
      while (k < 9) begin
         @(negedge clk);
         k++;
         if (k == 1) if_a.start = 1'b0;
      end
      chk("mid busy_before_rst", 32'(if_a.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst busy", 32'(if_a.busy), 32'd0);
      chk("mid_rst clk_sr", 32'(if_a.clk_sr), 32'd0);
      chk("mid_rst din_sr", 32'(if_a.din_sr), 32'd0);
      chk("mid_rst load_sr", 32'(if_a.load_sr), 32'd0);
      chk("mid_rst done", 32'(if_a.done), 32'd0);
      chk("mid_rst dout", 32'(if_a.dout), 32'd0);
      run_check("after_rst", 8'h3C, 8'h00, 0, 8'h3C, CMP_EN);

      // Random words and readback corruption against the arithmetic model
      for (int n = 0; n < 12; n++) begin
         w = 8'($urandom);
         case ($urandom_range(0, 2))
            0:       flip = 8'h00;
            1:       flip = 8'(1 << $urandom_range(0, 7));
            default: flip = 8'($urandom);
         endcase
         run_check($sformatf("rnd%0d", n), w, flip, 0, w ^ flip, CMP_EN && (flip == 8'h00));
      end

      // Default-size instance, all-ones word, readback pin held high
      @(negedge clk);
      if_b.din = '1; if_b.start = 1'b1;
      @(posedge clk);
      k = 0; lat = -1;
      while (k < 2000 && lat < 0) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            if_b.start = 1'b0;
            if_b.din   = '0;
         end
         if (if_b.done) lat = k;
      end
      chk("w170 latency", 32'(lat), 32'd1365);
      chk("w170 dout_all_ones", 32'(&if_b.dout), 32'd1);
      chk("w170 match", 32'(if_b.match), 32'(CMP_EN));
      @(negedge clk);
      chk("w170 busy_after", 32'(if_b.busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
